strobe_interval_meter: RTL and testbench
========================================

Name: strobe_interval_meter

Overview:
- Receive-side decoder for a counter_with_strobe channel. Measures how many enable ticks occur between successive strobe pulses, which recovers the divider's reset_value.
- Compares each measurement against an expected value and flags mismatch, overflow and a lost strobe stream (timeout).
- Sits beside a counter_with_strobe instance (self-check / monitor) or at the far end of a link that carries only tick and strobe.

Parameters:
- WIDTH, 4, width of measured interval, count and expected_value; max measurable interval 2^WIDTH-1.
- TIMEOUT, 1023, clock cycles allowed between strobes while locked before declaring loss; 0 disables timeout.
- TO_WIDTH, 16, width of internal timeout cycle counter; TIMEOUT must be < 2^TO_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  tick input; each high cycle is one counted event.
- strobe  input  1  interval-end marker, single-cycle pulse.
- expected_value  input  WIDTH  expected ticks per interval; sampled in the strobe cycle.
- count  output  WIDTH  measured ticks of last completed interval; held between updates.
- count_valid  output  1  one-cycle pulse: count/overflow/mismatch updated.
- overflow  output  1  last measurement saturated; held with count.
- mismatch  output  1  last measurement != expected_value or overflow; held with count.
- locked  output  1  high while in MEASURE state.
- timeout  output  1  one-cycle pulse when lock lost.

Behaviour:
- Reset (rst high at clock edge): state SYNC; count=0, count_valid=0, overflow=0, mismatch=0, locked=0, timeout=0; tick accumulator and timeout counter = 0. rst has priority over all inputs.
- States: SYNC, MEASURE. The first interval after reset or timeout is partial, so it is discarded.
- SYNC:
  - enable ignored; count/overflow/mismatch hold.
  - strobe -> MEASURE, accumulator=0, timeout counter=0.
  - No count_valid is generated for this strobe.
- MEASURE:
  - locked=1.
  - enable high without strobe: accumulator += 1, saturating at 2^WIDTH-1.
  - Incrementing while already saturated sets a sticky internal sat flag for the interval.
- Strobe in MEASURE:
  - Result = accumulator + enable (enable coincident with strobe counts toward the ending interval), saturating. The sat flag is also set if this add saturates.
  - Next cycle: count=result, overflow=sat, mismatch=(result != expected_value sampled in strobe cycle) OR sat, count_valid=1 for exactly one cycle.
  - Accumulator=0, sat=0, timeout counter=0 for the new interval.
  - Latency from strobe to count_valid is exactly 1 cycle.
- Back-to-back strobes (consecutive cycles) are legal. Each produces its own count_valid; an interval with no ticks gives count=0.
- Saturation arithmetic: count reports 2^WIDTH-1 when overflow=1; there is no wrap-around.
- Timeout (TIMEOUT != 0), MEASURE only:
  - The timeout counter increments every cycle without strobe.
  - When it reaches TIMEOUT and strobe is low: timeout=1 next cycle for one cycle, state -> SYNC, locked=0, accumulator cleared.
  - count/overflow/mismatch hold last values.
  - Strobe in the same cycle as the terminal count: the strobe wins, a normal measurement is made and no timeout occurs.
- rst mid-interval: the measurement in progress is dropped, no count_valid is generated, and SYNC is required again.
- count_valid and timeout are never high in the same cycle.
- Output flops are registered; there are no combinational paths from inputs to outputs.
- expected_value is only sampled in the strobe cycle, so it may change freely otherwise.

Test Plan:
- Reset, strobe, then 5 enable pulses (every other cycle) followed by strobe, expected_value=5 -> one count_valid pulse 1 cycle after second strobe, count=5, mismatch=0, overflow=0; first strobe gives no count_valid, locked rises after first strobe.
- Drive from a counter_with_strobe (WIDTH=4, reset_value=7, enable toggling) for 4 strobe periods, expected_value=7 -> four count_valid pulses, each count=7, mismatch=0.
- WIDTH=4, 20 ticks between strobes -> count=15, overflow=1, mismatch=1; next interval with 3 ticks, expected 3 -> count=3, overflow=0, mismatch=0.
- Enable high in strobe cycle, 2 ticks before it -> count=3; strobe on consecutive cycles with no ticks -> second count=0, two count_valid pulses.
- TIMEOUT=10, lock then no strobe -> timeout pulse 1 cycle after the 10th strobe-free cycle, locked=0, count unchanged; strobe exactly on the terminal cycle instead -> count_valid, no timeout, locked stays 1.
- Assert rst mid-interval after 4 ticks, release, strobe, 2 ticks, strobe -> no output for the aborted interval, count=2 only after the post-reset second strobe.

Source files
------------

// File: rtl/strobe_interval_meter.sv
// strobe_interval_meter
// Receive-side decoder for a tick/strobe channel. Counts enable ticks between
// successive strobes, reports the interval (saturating), compares it against
// an expected value, and declares loss of lock when strobes stop arriving.
module strobe_interval_meter #(
  parameter int WIDTH    = 4,
  parameter int TIMEOUT  = 1023,
  parameter int TO_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe,
  input  logic [WIDTH-1:0] expected_value,
  output logic [WIDTH-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             mismatch,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0]    MAX      = '1;
  localparam logic [WIDTH-1:0]    ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0] TO_ONE   = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  // Last timeout-counter value before loss is declared; the counter starts
  // at 0 in the first strobe-free cycle, so the TIMEOUT-th such cycle sees
  // TIMEOUT-1.
  localparam int unsigned         TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TO_LAST_I);
  localparam bit                  TO_EN     = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                sat_q, sat_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                mis_q, mis_d;
  logic                cv_q, cv_d;
  logic                tout_q, tout_d;
  logic [WIDTH-1:0]    res;
  logic                res_sat;

  // Saturating increment: holds at MAX instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic             inc);
    if (inc && (a != MAX)) return a + ONE;
    return a;
  endfunction

  // True when an increment is requested but the value is already at MAX.
  function automatic logic sat_hit(input logic [WIDTH-1:0] a,
                                   input logic             inc);
    return inc && (a == MAX);
  endfunction

  // Next-state, accumulator, timeout counter and output-register updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    to_d    = to_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mis_d   = mis_q;
    cv_d    = 1'b0;
    tout_d  = 1'b0;
    res     = sat_add(acc_q, enable);
    res_sat = sat_q | sat_hit(acc_q, enable);

    case (state_q)
      SYNC: begin
        // The interval before the first strobe is partial, so it is not
        // measured; this strobe only establishes lock.
        if (strobe) begin
          state_d = MEASURE;
          acc_d   = '0;
          sat_d   = 1'b0;
          to_d    = '0;
        end
      end
      MEASURE: begin
        if (strobe) begin
          // A tick coincident with the strobe belongs to the ending interval.
          count_d = res;
          ovf_d   = res_sat;
          mis_d   = (res != expected_value) | res_sat;
          cv_d    = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
          to_d    = '0;
        end else if (TO_EN && (to_q == TO_LAST)) begin
          tout_d  = 1'b1;
          state_d = SYNC;
          acc_d   = '0;
          sat_d   = 1'b0;
          to_d    = '0;
        end else begin
          if (enable) begin
            acc_d = sat_add(acc_q, 1'b1);
            sat_d = sat_q | sat_hit(acc_q, 1'b1);
          end
          if (TO_EN) begin
            to_d = to_q + TO_ONE;
          end
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State and output registers; reset has priority over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      to_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
      cv_q    <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      to_q    <= to_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mis_q   <= mis_d;
      cv_q    <= cv_d;
      tout_q  <= tout_d;
    end
  end

  assign count       = count_q;
  assign count_valid = cv_q;
  assign overflow    = ovf_q;
  assign mismatch    = mis_q;
  assign locked      = (state_q == MEASURE);
  assign timeout     = tout_q;

endmodule

// File: tb/tb_strobe_interval_meter.sv
// Directed testbench for strobe_interval_meter. Two instances share the
// stimulus: one with the default long timeout for measurement scenarios and
// one with TIMEOUT=10 for loss-of-lock scenarios.
module tb_strobe_interval_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       strobe = 1'b0;
  logic [3:0] expected_value = 4'd0;

  logic [3:0] count;
  logic       count_valid, overflow, mismatch, locked, timeout;
  logic [3:0] t_count;
  logic       t_count_valid, t_overflow, t_mismatch, t_locked, t_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  strobe_interval_meter #(.WIDTH(4), .TIMEOUT(1023), .TO_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .strobe(strobe),
    .expected_value(expected_value), .count(count), .count_valid(count_valid),
    .overflow(overflow), .mismatch(mismatch), .locked(locked), .timeout(timeout)
  );

  strobe_interval_meter #(.WIDTH(4), .TIMEOUT(10), .TO_WIDTH(16)) dut_to (
    .clk(clk), .rst(rst), .enable(enable), .strobe(strobe),
    .expected_value(expected_value), .count(t_count), .count_valid(t_count_valid),
    .overflow(t_overflow), .mismatch(t_mismatch), .locked(t_locked), .timeout(t_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs; on return, registered outputs reflect them.
  task automatic cyc(input logic en, input logic st, input logic [3:0] ev);
    enable = en;
    strobe = st;
    expected_value = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 4'd3);
    cyc(1'b1, 1'b1, 4'd3);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b expected 0", count_valid); end
    n_checks++; if (overflow !== 1'b0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b mis=%b expected 0 0", overflow, mismatch); end
    n_checks++; if (locked !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got locked=%b timeout=%b expected 0 0", locked, timeout); end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_basic();
    int pulses = 0;
    do_reset();
    cyc(1'b1, 1'b0, 4'd5);
    cyc(1'b1, 1'b0, 4'd5);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL basic_prelock: got locked=%b expected 0", locked); end
    cyc(1'b0, 1'b1, 4'd5);
    n_checks++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL basic_first_strobe_cv: got %b expected 0", count_valid); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_lock: got locked=%b expected 1", locked); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      if (count_valid) pulses++;
      cyc(1'b0, 1'b0, 4'd9);
      if (count_valid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL basic_no_early_cv: got %0d pulses expected 0", pulses); end
    cyc(1'b0, 1'b1, 4'd5);
    n_checks++; if (count_valid !== 1'b1) begin n_fail++; $display("FAIL basic_cv: got %b expected 1", count_valid); end
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", count); end
    n_checks++; if (mismatch !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got mis=%b ovf=%b expected 0 0", mismatch, overflow); end
    cyc(1'b0, 1'b0, 4'd0);
    n_checks++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL basic_cv_width: got %b expected 0", count_valid); end
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL basic_hold: got %0d expected 5", count); end
    // Short interval against a different expectation raises mismatch only.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd5);
    n_checks++; if (count !== 4'd4 || mismatch !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL basic_mismatch: got count=%0d mis=%b ovf=%b expected 4 1 0", count, mismatch, overflow); end
  endtask

  task automatic test_counter_stream();
    int k = 0;
    int pulses = 0;
    logic en = 1'b0;
    logic st;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      en = ~en;
      st = 1'b0;
      if (en) begin
        k++;
        if (k == 7) begin
          st = 1'b1;
          k = 0;
        end
      end
      cyc(en, st, 4'd7);
      if (count_valid) begin
        pulses++;
        n_checks++; if (count !== 4'd7 || mismatch !== 1'b0) begin n_fail++; $display("FAIL stream_count: got count=%0d mis=%b expected 7 0", count, mismatch); end
      end
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL stream_pulses: got %0d expected 4", pulses); end
  endtask

  task automatic test_overflow();
    do_reset();
    cyc(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd15);
    n_checks++; if (count_valid !== 1'b1 || count !== 4'd15) begin n_fail++; $display("FAIL ovf_count: got cv=%b count=%0d expected 1 15", count_valid, count); end
    n_checks++; if (overflow !== 1'b1 || mismatch !== 1'b1) begin n_fail++; $display("FAIL ovf_flags: got ovf=%b mis=%b expected 1 1", overflow, mismatch); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd3);
    n_checks++; if (count !== 4'd3 || overflow !== 1'b0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL ovf_recover: got count=%0d ovf=%b mis=%b expected 3 0 0", count, overflow, mismatch); end
    // Exactly full scale: 14 ticks plus one coincident with the strobe.
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 4'd15);
    n_checks++; if (count !== 4'd15 || overflow !== 1'b0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL ovf_fullscale: got count=%0d ovf=%b mis=%b expected 15 0 0", count, overflow, mismatch); end
    // 15 ticks plus a coincident one: the final add saturates.
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 4'd15);
    n_checks++; if (count !== 4'd15 || overflow !== 1'b1 || mismatch !== 1'b1) begin n_fail++; $display("FAIL ovf_strobe_add: got count=%0d ovf=%b mis=%b expected 15 1 1", count, overflow, mismatch); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 4'd3);
    n_checks++; if (count_valid !== 1'b1 || count !== 4'd3 || mismatch !== 1'b0) begin n_fail++; $display("FAIL b2b_coincident: got cv=%b count=%0d mis=%b expected 1 3 0", count_valid, count, mismatch); end
    cyc(1'b0, 1'b1, 4'd0);
    n_checks++; if (count_valid !== 1'b1 || count !== 4'd0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL b2b_zero: got cv=%b count=%0d mis=%b expected 1 0 0", count_valid, count, mismatch); end
    cyc(1'b0, 1'b1, 4'd1);
    n_checks++; if (count_valid !== 1'b1 || count !== 4'd0 || mismatch !== 1'b1) begin n_fail++; $display("FAIL b2b_zero_mis: got cv=%b count=%0d mis=%b expected 1 0 1", count_valid, count, mismatch); end
    cyc(1'b0, 1'b0, 4'd0);
    n_checks++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got cv=%b expected 0", count_valid); end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd2);
    n_checks++; if (t_count !== 4'd2 || t_count_valid !== 1'b1) begin n_fail++; $display("FAIL to_setup: got count=%0d cv=%b expected 2 1", t_count, t_count_valid); end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 4'd0);
      if (t_timeout !== 1'b0 || t_locked !== 1'b1) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early: got %0d bad cycles expected 0", early); end
    cyc(1'b0, 1'b0, 4'd0);
    n_checks++; if (t_timeout !== 1'b1 || t_locked !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got timeout=%b locked=%b expected 1 0", t_timeout, t_locked); end
    n_checks++; if (t_count !== 4'd2 || t_count_valid !== 1'b0 || t_mismatch !== 1'b0) begin n_fail++; $display("FAIL to_hold: got count=%0d cv=%b mis=%b expected 2 0 0", t_count, t_count_valid, t_mismatch); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_long_lock: got locked=%b expected 1", locked); end
    cyc(1'b1, 1'b0, 4'd0);
    n_checks++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b expected 0", t_timeout); end
    // Relock: this strobe must not produce a measurement.
    cyc(1'b0, 1'b1, 4'd0);
    n_checks++; if (t_count_valid !== 1'b0 || t_locked !== 1'b1) begin n_fail++; $display("FAIL to_relock: got cv=%b locked=%b expected 0 1", t_count_valid, t_locked); end
    for (int i = 0; i < 9; i++) cyc((i < 3) ? 1'b1 : 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd3);
    n_checks++; if (t_count_valid !== 1'b1 || t_timeout !== 1'b0 || t_locked !== 1'b1) begin n_fail++; $display("FAIL to_strobe_wins: got cv=%b timeout=%b locked=%b expected 1 0 1", t_count_valid, t_timeout, t_locked); end
    n_checks++; if (t_count !== 4'd3 || t_mismatch !== 1'b0) begin n_fail++; $display("FAIL to_strobe_count: got count=%0d mis=%b expected 3 0", t_count, t_mismatch); end
    cyc(1'b0, 1'b0, 4'd0);
    n_checks++; if (t_timeout !== 1'b0 || t_locked !== 1'b1) begin n_fail++; $display("FAIL to_after: got timeout=%b locked=%b expected 0 1", t_timeout, t_locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'd0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 4'd4);
    rst = 1'b0;
    n_checks++; if (count_valid !== 1'b0 || locked !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL mid_reset: got cv=%b locked=%b count=%0d expected 0 0 0", count_valid, locked, count); end
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd0);
    n_checks++; if (count_valid !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock: got cv=%b locked=%b expected 0 1", count_valid, locked); end
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd2);
    n_checks++; if (count_valid !== 1'b1 || count !== 4'd2 || mismatch !== 1'b0) begin n_fail++; $display("FAIL mid_measure: got cv=%b count=%0d mis=%b expected 1 2 0", count_valid, count, mismatch); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_counter_stream();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
